// File: rtl/sdram_sync_fifo_pkg.sv
// Shared constants and helpers for the SDRAM write-path FIFO.
package sdram_fifo_pkg;

   localparam int SDRAM_FIFO_DW    = 16;
   localparam int SDRAM_FIFO_DEPTH = 1024;
   localparam int SDRAM_BURST_LEN  = 256;

   // Width of a fill counter able to hold 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sdram_sync_fifo_if.sv
// Write/read/status bundle between the pixel producer and the FIFO.
interface sdram_sync_fifo_if
   import sdram_fifo_pkg::*;
#(
   parameter int DATA_W = SDRAM_FIFO_DW,
   parameter int DEPTH  = SDRAM_FIFO_DEPTH
) ();

   logic [DATA_W-1:0]       di;
   logic                    we;
   logic                    re;
   logic                    clr_err;
   logic [DATA_W-1:0]       dout;
   logic                    dout_valid;
   logic                    empty_flag;
   logic                    full_flag;
   logic                    aempty_flag;
   logic                    afull_flag;
   logic                    burst_rdy;
   logic [cnt_w(DEPTH)-1:0] count;
   logic                    ovf;
   logic                    udf;

   modport master (
      output di, we, re, clr_err,
      input  dout, dout_valid, empty_flag, full_flag, aempty_flag, afull_flag,
             burst_rdy, count, ovf, udf
   );

   modport slave (
      input  di, we, re, clr_err,
      output dout, dout_valid, empty_flag, full_flag, aempty_flag, afull_flag,
             burst_rdy, count, ovf, udf
   );

endinterface

// File: rtl/sdram_sync_fifo_ram.sv
// Simple dual-port storage: one write port, one synchronous read port.
// The read register doubles as the FIFO output stage, so it is reset
// while the array itself is left untouched.
module sdram_fifo_ram #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 1024,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Array write port.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read port; holds its value when not enabled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_sync_fifo.sv
// Single-clock FIFO feeding the SDRAM burst engine: pointers, fill count,
// registered status flags, optional FWFT output stage, sticky error flags.
module sdram_sync_fifo
   import sdram_fifo_pkg::*;
#(
   parameter int DATA_W    = SDRAM_FIFO_DW,
   parameter int DEPTH     = SDRAM_FIFO_DEPTH,
   parameter int AE_LVL    = 8,
   parameter int AF_LVL    = DEPTH - 8,
   parameter int BURST_LEN = SDRAM_BURST_LEN,
   parameter int FWFT      = 1
) (
   input logic              clk,
   input logic              rst_n,
   sdram_sync_fifo_if.slave bus
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = cnt_w(DEPTH);

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [AW-1:0]    ptr_t;

   localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
   localparam cnt_t AE_C     = cnt_t'(AE_LVL);
   localparam cnt_t AF_C     = cnt_t'(AF_LVL);
   localparam cnt_t BURST_C  = cnt_t'(BURST_LEN);
   localparam cnt_t CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam ptr_t PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam bit   FWFT_MODE = (FWFT != 0);

   if (!((AE_LVL < AF_LVL) && (AF_LVL <= DEPTH) && (BURST_LEN >= 1) &&
         (BURST_LEN <= DEPTH) && (DEPTH >= 4) && ((DEPTH & (DEPTH - 1)) == 0)))
   begin : g_bad_params
      $error("sdram_sync_fifo: illegal DEPTH/AE_LVL/AF_LVL/BURST_LEN combination");
   end

   ptr_t wr_ptr_q, wr_ptr_d;
   ptr_t rd_ptr_q, rd_ptr_d;
   cnt_t count_q, count_d;
   logic dout_valid_q, dout_valid_d;
   logic empty_q, empty_d;
   logic full_q, full_d;
   logic aempty_q, aempty_d;
   logic afull_q, afull_d;
   logic burst_q, burst_d;
   logic ovf_q, ovf_d;
   logic udf_q, udf_d;

   logic              wr_acc;
   logic              re_acc;
   logic              ram_rd;
   cnt_t              ram_cnt;
   logic [DATA_W-1:0] ram_rdata;

   // The RAM read register is the output stage in both modes, so dout
   // never needs a separate copy.
   sdram_fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q),
      .wdata_i (bus.di),
      .re_i    (ram_rd),
      .raddr_i (rd_ptr_q),
      .rdata_o (ram_rdata)
   );

   // Accept decisions, RAM read scheduling and next-state count/flags.
   always_comb begin
      wr_acc = bus.we && !full_q;
      re_acc = bus.re && !empty_q;

      // In FWFT mode the displayed word has already left the RAM.
      ram_cnt = FWFT_MODE ? (count_q - cnt_t'(dout_valid_q)) : count_q;

      // FWFT refills the stage whenever it is empty or being consumed,
      // which keeps continuous reads free of bubbles.
      if (FWFT_MODE) begin
         ram_rd = (ram_cnt != '0) && (!dout_valid_q || re_acc);
      end else begin
         ram_rd = re_acc;
      end

      wr_ptr_d = wr_acc ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = ram_rd ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

      case ({wr_acc, re_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      if (FWFT_MODE) begin
         if (ram_rd) begin
            dout_valid_d = 1'b1;
         end else if (re_acc) begin
            dout_valid_d = 1'b0;
         end else begin
            dout_valid_d = dout_valid_q;
         end
         empty_d = !dout_valid_d;
      end else begin
         dout_valid_d = re_acc;
         empty_d      = (count_d == '0);
      end

      full_d   = (count_d == DEPTH_C);
      aempty_d = (count_d <= AE_C);
      afull_d  = (count_d >= AF_C);
      burst_d  = (count_d >= BURST_C);

      ovf_d = bus.clr_err ? 1'b0 : (ovf_q || (bus.we && full_q));
      udf_d = bus.clr_err ? 1'b0 : (udf_q || (bus.re && empty_q));
   end

   // State and flag registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         dout_valid_q <= 1'b0;
         empty_q      <= 1'b1;
         full_q       <= 1'b0;
         aempty_q     <= 1'b1;
         afull_q      <= 1'b0;
         burst_q      <= 1'b0;
         ovf_q        <= 1'b0;
         udf_q        <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         dout_valid_q <= dout_valid_d;
         empty_q      <= empty_d;
         full_q       <= full_d;
         aempty_q     <= aempty_d;
         afull_q      <= afull_d;
         burst_q      <= burst_d;
         ovf_q        <= ovf_d;
         udf_q        <= udf_d;
      end
   end

   assign bus.dout        = ram_rdata;
   assign bus.dout_valid  = dout_valid_q;
   assign bus.empty_flag  = empty_q;
   assign bus.full_flag   = full_q;
   assign bus.aempty_flag = aempty_q;
   assign bus.afull_flag  = afull_q;
   assign bus.burst_rdy   = burst_q;
   assign bus.count       = count_q;
   assign bus.ovf         = ovf_q;
   assign bus.udf         = udf_q;

endmodule

// File: tb/tb_sdram_sync_fifo.sv
// Directed bench for sdram_sync_fifo: one FWFT instance and one
// standard-read instance sharing clock and reset.
module tb_sdram_sync_fifo;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   logic [15:0] q[$];
   int   wr_n;
   int   rd_n;

   always #5 clk = ~clk;

   sdram_sync_fifo_if #(.DATA_W(16), .DEPTH(16)) bus  ();
   sdram_sync_fifo_if #(.DATA_W(16), .DEPTH(16)) bus0 ();

   sdram_sync_fifo #(
      .DATA_W(16), .DEPTH(16), .AE_LVL(2), .AF_LVL(14), .BURST_LEN(8), .FWFT(1)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   sdram_sync_fifo #(
      .DATA_W(16), .DEPTH(16), .AE_LVL(2), .AF_LVL(14), .BURST_LEN(8), .FWFT(0)
   ) u_std (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Status flags of the FWFT instance as implied by a fill level.
   task automatic chk_lvl(input string tag, input int n);
      chk({tag, "_count"},  bus.count,       n);
      chk({tag, "_full"},   bus.full_flag,   (n == 16));
      chk({tag, "_afull"},  bus.afull_flag,  (n >= 14));
      chk({tag, "_aempty"}, bus.aempty_flag, (n <= 2));
      chk({tag, "_burst"},  bus.burst_rdy,   (n >= 8));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.di = '0;  bus.we = 1'b0;  bus.re = 1'b0;  bus.clr_err = 1'b0;
      bus0.di = '0; bus0.we = 1'b0; bus0.re = 1'b0; bus0.clr_err = 1'b0;

      // Reset held for two clocks.
      step();
      step();
      chk_lvl("rst", 0);
      chk("rst_empty", bus.empty_flag, 1);
      chk("rst_dout",  bus.dout, 0);
      chk("rst_dv",    bus.dout_valid, 0);
      chk("rst_ovf",   bus.ovf, 0);
      chk("rst_udf",   bus.udf, 0);
      chk("rst0_count", bus0.count, 0);
      chk("rst0_empty", bus0.empty_flag, 1);
      chk("rst0_dout",  bus0.dout, 0);

      rst_n = 1'b1;
      step();
      chk_lvl("idle", 0);
      chk("idle_empty", bus.empty_flag, 1);

      // First write: count after one edge, dout after two.
      bus.we = 1'b1; bus.di = 16'h1234;
      step();
      bus.we = 1'b0;
      chk("w1_count", bus.count, 1);
      chk("w1_empty", bus.empty_flag, 1);
      chk("w1_dv",    bus.dout_valid, 0);
      step();
      chk("w2_dout",  bus.dout, 16'h1234);
      chk("w2_dv",    bus.dout_valid, 1);
      chk("w2_empty", bus.empty_flag, 0);
      chk("w2_count", bus.count, 1);
      bus.re = 1'b1;
      step();
      bus.re = 1'b0;
      chk("r1_count", bus.count, 0);
      chk("r1_empty", bus.empty_flag, 1);
      chk("r1_dv",    bus.dout_valid, 0);
      chk("r1_udf",   bus.udf, 0);

      // Fill 0x0000..0x000F, watching threshold flags.
      bus.we = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus.di = 16'(i);
         step();
         chk_lvl("fill", i + 1);
      end
      chk("fill_dout", bus.dout, 16'h0000);
      chk("fill_dv",   bus.dout_valid, 1);
      bus.di = 16'h0011;
      step();
      bus.we = 1'b0;
      chk_lvl("ovfw", 16);
      chk("ovfw_ovf", bus.ovf, 1);
      step();
      chk("ovf_sticky", bus.ovf, 1);
      bus.clr_err = 1'b1;
      step();
      chk("ovf_clr", bus.ovf, 0);
      bus.we = 1'b1;
      step();
      bus.we = 1'b0; bus.clr_err = 1'b0;
      chk("clr_prio", bus.ovf, 0);
      chk("clr_prio_count", bus.count, 16);

      // Drain with re held: no bubbles, in order.
      bus.re = 1'b1;
      for (int k = 0; k < 16; k++) begin
         step();
         chk_lvl("drain", 15 - k);
         chk("drain_empty", bus.empty_flag, (k == 15));
         if (k < 15) begin
            chk("drain_dv",   bus.dout_valid, 1);
            chk("drain_dout", bus.dout, k + 1);
         end
      end
      step();
      bus.re = 1'b0;
      chk("udf_set", bus.udf, 1);
      chk("udf_count", bus.count, 0);
      bus.clr_err = 1'b1;
      step();
      bus.clr_err = 1'b0;
      chk("udf_clr", bus.udf, 0);

      // Simultaneous read/write at count 5.
      bus.we = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.di = 16'(16'h0100 + i);
         step();
      end
      chk("sim_pre_count", bus.count, 5);
      chk("sim_pre_dout",  bus.dout, 16'h0100);
      bus.re = 1'b1;
      for (int j = 0; j < 10; j++) begin
         bus.di = 16'(16'h0105 + j);
         step();
         chk("sim_count", bus.count, 5);
         chk("sim_dout",  bus.dout, 16'h0101 + j);
      end
      bus.we = 1'b0;
      for (int j = 0; j < 5; j++) begin
         step();
         chk("sim_drain_count", bus.count, 4 - j);
         if (j < 4) chk("sim_drain_dout", bus.dout, 16'h010B + j);
      end
      bus.re = 1'b0;

      // Full with we+re: read wins, write rejected.
      bus.we = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus.di = 16'(16'h0200 + i);
         step();
      end
      chk("fwr_full", bus.full_flag, 1);
      bus.re = 1'b1; bus.di = 16'h02FF;
      step();
      bus.we = 1'b0;
      chk("fwr_count", bus.count, 15);
      chk("fwr_ovf",   bus.ovf, 1);
      chk("fwr_dout",  bus.dout, 16'h0201);
      for (int j = 0; j < 15; j++) begin
         step();
         chk("fwr_drain_count", bus.count, 14 - j);
         if (j < 14) chk("fwr_drain_dout", bus.dout, 16'h0202 + j);
      end
      bus.re = 1'b0; bus.clr_err = 1'b1;
      step();
      bus.clr_err = 1'b0;
      chk("fwr_empty", bus.empty_flag, 1);

      // Wrap: 40 writes/reads with random gaps against a queue model.
      wr_n = 0;
      rd_n = 0;
      q.delete();
      for (int cyc = 0; cyc < 400 && (wr_n < 40 || rd_n < 40); cyc++) begin
         bus.we = (wr_n < 40) && !bus.full_flag && ($urandom_range(0, 3) != 0);
         bus.di = 16'(16'h3000 + wr_n);
         bus.re = (rd_n < 40) && !bus.empty_flag && ($urandom_range(0, 3) != 0);
         if (bus.re) chk("wrap_data", bus.dout, q[0]);
         step();
         if (bus.re) begin
            void'(q.pop_front());
            rd_n++;
         end
         if (bus.we) begin
            q.push_back(bus.di);
            wr_n++;
         end
         chk("wrap_count", bus.count, q.size());
      end
      bus.we = 1'b0; bus.re = 1'b0;
      chk("wrap_done", (wr_n == 40) && (rd_n == 40), 1);
      chk("wrap_ovf", bus.ovf, 0);
      chk("wrap_udf", bus.udf, 0);

      // Reset mid-operation discards everything.
      bus.we = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.di = 16'(16'h0500 + i);
         step();
      end
      bus.we = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk_lvl("mrst", 0);
      chk("mrst_dout",  bus.dout, 0);
      chk("mrst_dv",    bus.dout_valid, 0);
      chk("mrst_empty", bus.empty_flag, 1);
      bus.we = 1'b1; bus.di = 16'h0777;
      step();
      bus.we = 1'b0;
      step();
      chk("mrst_new_dout", bus.dout, 16'h0777);
      chk("mrst_new_count", bus.count, 1);

      // Standard (registered) read mode.
      bus0.we = 1'b1; bus0.di = 16'hA5A5;
      step();
      bus0.we = 1'b0;
      chk("std_w_count", bus0.count, 1);
      chk("std_w_empty", bus0.empty_flag, 0);
      chk("std_w_dv",    bus0.dout_valid, 0);
      chk("std_w_dout",  bus0.dout, 0);
      bus0.re = 1'b1;
      step();
      bus0.re = 1'b0;
      chk("std_r_dout",  bus0.dout, 16'hA5A5);
      chk("std_r_dv",    bus0.dout_valid, 1);
      chk("std_r_count", bus0.count, 0);
      chk("std_r_empty", bus0.empty_flag, 1);
      step();
      chk("std_hold_dout", bus0.dout, 16'hA5A5);
      chk("std_hold_dv",   bus0.dout_valid, 0);
      bus0.re = 1'b1;
      step();
      bus0.re = 1'b0;
      chk("std_udf",      bus0.udf, 1);
      chk("std_udf_dout", bus0.dout, 16'hA5A5);
      chk("std_udf_dv",   bus0.dout_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
